// File: rtl/btn_pkg.sv
// Shared types and constants for the button lockout scheduler family.
package btn_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCK,
        ST_HOLD
    } btn_state_t;

    // Defaults for the 24 MHz system clock: 150 ms lockout, 300 ms repeat.
    localparam int DEF_LOCKOUT_CYCLES = 3600000;
    localparam int DEF_REPEAT_CYCLES  = 7200000;

    // Counter must be able to hold the larger of the two terminal values.
    function automatic int cnt_width(input int lock_c, input int rep_c);
        int m;
        m = (lock_c > rep_c) ? lock_c : rep_c;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/btn_rr_pick.sv
// Combinational round-robin picker: first set request after i_ptr, wrapping.
module btn_rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_vld,
    output logic [IW-1:0] o_idx
);

    logic [IW-1:0] w_j;

    assign o_vld = |i_req;

    // Walk from farthest to nearest so the nearest set bit after i_ptr wins.
    always_comb begin
        o_idx = '0;
        w_j   = '0;
        for (int k = N; k >= 1; k--) begin
            w_j = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) o_idx = w_j;
        end
    end

endmodule

// File: rtl/btn_lockout_sched.sv
// Shared-lockout button debouncer / scheduler.
// Optional auto-repeat while held: define BTN_AUTOREPEAT_EN.
module btn_lockout_sched
    import btn_pkg::*;
#(
    parameter int N_BTN          = 4,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int REPEAT_CYCLES  = DEF_REPEAT_CYCLES
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_BTN-1:0]         btn_raw,
    output logic [N_BTN-1:0]         pulse_o,
    output logic [$clog2(N_BTN)-1:0] grant_idx,
    output logic                     busy
);

    localparam int IW = $clog2(N_BTN);
    localparam int CW = cnt_width(LOCKOUT_CYCLES, REPEAT_CYCLES);

    logic [N_BTN-1:0] r_sync1, r_s, r_s_d, r_pend, r_pulse;
    logic [IW-1:0]    r_rr, r_grant;
    logic [CW-1:0]    r_cnt;
    logic             r_busy;
    btn_state_t       r_state;

    logic [N_BTN-1:0] w_rise, w_ign, w_clr;
    logic             w_pick_vld;
    logic [IW-1:0]    w_pick_idx;

    assign pulse_o   = r_pulse;
    assign grant_idx = r_grant;
    assign busy      = r_busy;

    assign w_rise = r_s & ~r_s_d;
    // A re-rise of the granted button while locked out is contact bounce.
    assign w_ign  = (r_state == ST_LOCK) ? (N_BTN'(1) << r_grant) : '0;
    assign w_clr  = (r_state == ST_IDLE && w_pick_vld) ? (N_BTN'(1) << w_pick_idx) : '0;

    btn_rr_pick #(.N(N_BTN), .IW(IW)) u_pick (
        .i_req (r_pend),
        .i_ptr (r_rr),
        .o_vld (w_pick_vld),
        .o_idx (w_pick_idx)
    );

    // Two-flop synchroniser plus delayed copy for rising-edge detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_sync1 <= '0;
            r_s     <= '0;
            r_s_d   <= '0;
        end else begin
            r_sync1 <= btn_raw;
            r_s     <= r_sync1;
            r_s_d   <= r_s;
        end
    end

    // Pending presses: the grant clears its own bit, new rises on other bits still land.
    always_ff @(posedge clk) begin
        if (!rst_n) r_pend <= '0;
        else        r_pend <= (r_pend & ~w_clr) | (w_rise & ~w_ign & ~w_clr);
    end

    // Scheduler FSM: grant from IDLE, time the shared lockout, optional hold/repeat.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_rr    <= IW'(N_BTN - 1);
            r_grant <= '0;
            r_cnt   <= '0;
            r_pulse <= '0;
            r_busy  <= 1'b0;
        end else begin
            r_pulse <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_pick_vld) begin
                        r_pulse <= N_BTN'(1) << w_pick_idx;
                        r_grant <= w_pick_idx;
                        r_rr    <= w_pick_idx;
                        r_cnt   <= '0;
                        r_state <= ST_LOCK;
                        r_busy  <= 1'b1;
                    end
                end
                ST_LOCK: begin
                    if (r_cnt == CW'(LOCKOUT_CYCLES - 1)) begin
`ifdef BTN_AUTOREPEAT_EN
                        if (r_s[r_grant]) begin
                            r_state <= ST_HOLD;
                            r_cnt   <= '0;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                        end
`else
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
`endif
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef BTN_AUTOREPEAT_EN
                // HOLD spans REPEAT_CYCLES+1 cycles, so repeats recur every
                // LOCKOUT_CYCLES+REPEAT_CYCLES+1 cycles; rr pointer untouched.
                ST_HOLD: begin
                    if (!r_s[r_grant]) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_cnt == CW'(REPEAT_CYCLES)) begin
                        r_pulse <= N_BTN'(1) << r_grant;
                        r_state <= ST_LOCK;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
